// File: rtl/hc595_pkg.sv
// Shared constants and frame layout for the 74HC595-style serial display link.
// The first bit shifted in lands in the MSB of the segment field.
package hc595_pkg;

  localparam int FRAME_BITS = 14;
  localparam int SEL_W      = 6;
  localparam int SEG_W      = 8;
  localparam int CNT_W      = 4;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_BITS);

  typedef struct packed {
    logic [SEG_W-1:0] seg;
    logic [SEL_W-1:0] sel;
  } frame_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  endfunction

endpackage

// File: rtl/hc595_rx_sync_edge.sv
// N-flop synchronizer with a registered rising-edge flag that is high in the
// first cycle the synchronized output reads 1 after having read 0.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic sync,
  output logic rise
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              rise_q, rise_d;

  // The flag is computed one stage early so it lines up with the cycle in
  // which the last stage first shows the new level.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    rise_d = sync_q[STAGES-2] & ~sync_q[STAGES-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rise_q <= rise_d;
    end
  end

  assign sync = sync_q[STAGES-1];
  assign rise = rise_q;

endmodule

// File: rtl/hc595_rx.sv
// Receiver for a 74HC595-style display link: synchronizes ds/shcp/stcp/oe,
// shifts 14-bit frames, latches them to sel/seg and flags frame length.
module hc595_rx
  import hc595_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             ds,
  input  logic             shcp,
  input  logic             stcp,
  input  logic             oe,
  output logic [SEL_W-1:0] sel,
  output logic [SEG_W-1:0] seg,
  output logic             disp_on,
  output logic             frame_valid,
  output logic             frame_err
);

  logic ds_sync, shcp_rise, stcp_rise, oe_sync;
  logic shcp_sync_unused, stcp_sync_unused, ds_rise_unused, oe_rise_unused;

  // ds shares the shcp depth so the sampled bit matches the detected edge.
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ds (
    .clk(sys_clk), .rst_n(sys_rst_n), .d(ds),   .sync(ds_sync),          .rise(ds_rise_unused));
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_shcp (
    .clk(sys_clk), .rst_n(sys_rst_n), .d(shcp), .sync(shcp_sync_unused), .rise(shcp_rise));
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_stcp (
    .clk(sys_clk), .rst_n(sys_rst_n), .d(stcp), .sync(stcp_sync_unused), .rise(stcp_rise));
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_oe (
    .clk(sys_clk), .rst_n(sys_rst_n), .d(oe),   .sync(oe_sync),          .rise(oe_rise_unused));

  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  frame_t                store_q, store_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  disp_on_q, disp_on_d;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    sr_d          = sr_q;
    bit_cnt_d     = bit_cnt_q;
    store_d       = store_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    disp_on_d     = ~oe_sync;

    if (shcp_rise) begin
      sr_d      = {sr_q[FRAME_BITS-2:0], ds_sync};
      bit_cnt_d = sat_inc(bit_cnt_q);
    end

    // Latch sees the post-shift word and count when both edges coincide.
    if (stcp_rise) begin
      store_d       = frame_t'(sr_d);
      frame_valid_d = (bit_cnt_d == CNT_FRAME);
      frame_err_d   = (bit_cnt_d != CNT_FRAME);
      bit_cnt_d     = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sr_q          <= '0;
      bit_cnt_q     <= '0;
      store_q       <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      disp_on_q     <= 1'b0;
    end else begin
      sr_q          <= sr_d;
      bit_cnt_q     <= bit_cnt_d;
      store_q       <= store_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      disp_on_q     <= disp_on_d;
    end
  end

  assign sel         = store_q.sel;
  assign seg         = store_q.seg;
  assign disp_on     = disp_on_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_hc595_rx.sv
// Directed bench for hc595_rx: frame lengths, coincident shift/latch, reset
// mid-frame and oe latency, all against hand-computed values.
module tb_hc595_rx;

  logic       sys_clk, sys_rst_n, ds, shcp, stcp, oe;
  logic [5:0] sel;
  logic [7:0] seg;
  logic       disp_on, frame_valid, frame_err;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int fv0, fe0;

  hc595_rx #(.SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ds(ds), .shcp(shcp), .stcp(stcp),
    .oe(oe), .sel(sel), .seg(seg), .disp_on(disp_on),
    .frame_valid(frame_valid), .frame_err(frame_err));

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (frame_valid) fv_cnt++;
    if (frame_err) fe_cnt++;
    if (frame_valid && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic shift_bit(input logic b);
    ds = b;
    step(2);
    shcp = 1'b1;
    step(2);
    shcp = 1'b0;
    step(2);
  endtask

  task automatic shift_word(input logic [15:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) shift_bit(w[i]);
  endtask

  task automatic latch();
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    stcp = 1'b1;
    step(3);
    stcp = 1'b0;
    step(4);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    ds = 1'b0; shcp = 1'b0; stcp = 1'b0; oe = 1'b1;
    step(3);
    check("rst_sel", 32'(sel), 32'h00);
    check("rst_seg", 32'(seg), 32'h00);
    check("rst_fv", 32'(frame_valid), 32'h0);
    check("rst_fe", 32'(frame_err), 32'h0);
    check("rst_disp_on", 32'(disp_on), 32'h0);
    sys_rst_n = 1'b1;
    step(6);

    // Full frame seg=C0 sel=3E, checking latch latency edge by edge.
    shift_word(16'h303E, 14);
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    stcp = 1'b1;
    step(2);
    check("t1_seg_before_3rd_edge", 32'(seg), 32'h00);
    step(1);
    check("t1_seg", 32'(seg), 32'hC0);
    check("t1_sel", 32'(sel), 32'h3E);
    check("t1_fv_now", 32'(frame_valid), 32'h1);
    stcp = 1'b0;
    step(4);
    check("t1_fv_pulses", 32'(fv_cnt - fv0), 32'd1);
    check("t1_fe_pulses", 32'(fe_cnt - fe0), 32'd0);

    // 13 bits: sr = {old sr[0]=0, 13'h1555} = 14'h1555.
    shift_word(16'h1555, 13);
    latch();
    check("t2_seg", 32'(seg), 32'h55);
    check("t2_sel", 32'(sel), 32'h15);
    check("t2_fe_pulses", 32'(fe_cnt - fe0), 32'd1);
    check("t2_fv_pulses", 32'(fv_cnt - fv0), 32'd0);

    // 16 bits: last 14 of A5F0 = 25F0 -> seg 97, sel 30.
    shift_word(16'hA5F0, 16);
    latch();
    check("t3_seg", 32'(seg), 32'h97);
    check("t3_sel", 32'(sel), 32'h30);
    check("t3_fe_pulses", 32'(fe_cnt - fe0), 32'd1);
    check("t3_fv_pulses", 32'(fv_cnt - fv0), 32'd0);

    // 13 bits of word 0F2D, 14th bit (1) shifted in the same cycle as the latch.
    shift_word(16'h0796, 13);
    ds = 1'b1;
    step(2);
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    shcp = 1'b1;
    stcp = 1'b1;
    step(3);
    shcp = 1'b0;
    stcp = 1'b0;
    step(4);
    check("t4_seg", 32'(seg), 32'h3C);
    check("t4_sel", 32'(sel), 32'h2D);
    check("t4_fv_pulses", 32'(fv_cnt - fv0), 32'd1);
    check("t4_fe_pulses", 32'(fe_cnt - fe0), 32'd0);

    // Reset mid-frame, then only 7 fresh bits before the latch.
    shift_word(16'h007F, 7);
    sys_rst_n = 1'b0;
    step(1);
    check("t5_rst_sel", 32'(sel), 32'h00);
    check("t5_rst_seg", 32'(seg), 32'h00);
    sys_rst_n = 1'b1;
    step(5);
    shift_word(16'h0059, 7);
    latch();
    check("t5_seg", 32'(seg), 32'h01);
    check("t5_sel", 32'(sel), 32'h19);
    check("t5_fe_pulses", 32'(fe_cnt - fe0), 32'd1);
    check("t5_fv_pulses", 32'(fv_cnt - fv0), 32'd0);

    // oe falling: disp_on rises on the third edge; sel/seg untouched.
    check("t6_disp_on_idle", 32'(disp_on), 32'h0);
    oe = 1'b0;
    step(2);
    check("t6_disp_on_2_edges", 32'(disp_on), 32'h0);
    step(1);
    check("t6_disp_on_3_edges", 32'(disp_on), 32'h1);
    check("t6_seg_held", 32'(seg), 32'h01);
    check("t6_sel_held", 32'(sel), 32'h19);

    check("never_both_flags", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
